// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and tables for keypad_emulator (bounce option: KEYPAD_EMU_BOUNCE_EN)
package keypad_pkg;

`ifdef KEYPAD_EMU_BOUNCE_EN
    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        BOUNCE_IN,
        BOUNCE_OUT
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;
`endif

    // Cycles spent in each bounce window.
    localparam int BOUNCE_LEN = 16;

    // Value the bounce LFSR restarts from on reset and on every accepted request.
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Key code -> {column index, row index}; entry 15 is listed first.
    localparam logic [15:0][3:0] KEY_TABLE = {
        4'hC,   // F: (3,0)
        4'h4,   // E: (1,0)
        4'h0,   // D: (0,0)
        4'h1,   // C: (0,1)
        4'h2,   // B: (0,2)
        4'h3,   // A: (0,3)
        4'h5,   // 9: (1,1)
        4'h9,   // 8: (2,1)
        4'hD,   // 7: (3,1)
        4'h6,   // 6: (1,2)
        4'hA,   // 5: (2,2)
        4'hE,   // 4: (3,2)
        4'h7,   // 3: (1,3)
        4'hB,   // 2: (2,3)
        4'hF,   // 1: (3,3)
        4'h8    // 0: (2,0)
    };

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Fibonacci step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
`endif

endpackage

// File: rtl/keypad_keymap.sv
// rtl/keypad_keymap.sv - combinational key code to (column, row) lookup
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [3:0] key,
    output logic [1:0] col_idx,
    output logic [1:0] row_idx
);

    assign col_idx = KEY_TABLE[key][3:2];
    assign row_idx = KEY_TABLE[key][1:0];

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - matrix keypad emulator top (optional contact bounce: KEYPAD_EMU_BOUNCE_EN)
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_key,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic [3:0]        col,
    output logic [3:0]        row,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int BASE_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
    localparam int CNT_W  = (BASE_W > 5) ? BASE_W : 5;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_PRE  = (GAP_CYCLES >= 2) ? CNT_W'(GAP_CYCLES - 2) : '0;
    localparam logic             GAP_ONE  = (GAP_CYCLES == 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        key_q;
    logic [HOLD_W-1:0] hold_q;
    logic              pressed;
    logic              done_q;
    logic [CNT_W-1:0]  hold_last;
    logic [1:0]        col_idx;
    logic [1:0]        row_idx;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_LEN - 1);
    logic [7:0] lfsr;
    logic [7:0] lfsr_nx;
    assign lfsr_nx = lfsr_next(lfsr);
`endif

    keypad_keymap u_keymap (
        .key     (key_q),
        .col_idx (col_idx),
        .row_idx (row_idx)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;

    // Final PRESS count value; a zero hold is stretched to one cycle.
    always_comb begin
        hold_last = '0;
        if (hold_q > HOLD_W'(1)) begin
            hold_last = CNT_W'(hold_q - HOLD_W'(1));
        end
    end

    // Pull the mapped row low only while the key is down and its column is being driven.
    always_comb begin
        row = 4'hF;
        if (pressed && !col[col_idx]) begin
            row = ~(4'b0001 << row_idx);
        end
    end

    // Request sequencer: accept, hold the key, release for the gap, pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            key_q   <= '0;
            hold_q  <= '0;
            pressed <= 1'b0;
            done_q  <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            lfsr    <= LFSR_SEED;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        key_q  <= req_key;
                        hold_q <= req_hold;
                        cnt    <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state   <= BOUNCE_IN;
                        lfsr    <= LFSR_SEED;
                        pressed <= LFSR_SEED[0];
`else
                        state   <= PRESS;
                        pressed <= 1'b1;
`endif
                    end
                end
                PRESS: begin
                    if (cnt == hold_last) begin
                        cnt <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state   <= BOUNCE_OUT;
                        lfsr    <= lfsr_nx;
                        pressed <= lfsr_nx[0];
`else
                        state   <= GAP;
                        pressed <= 1'b0;
                        done_q  <= GAP_ONE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        done_q <= (cnt == GAP_PRE);
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_IN: begin
                    if (cnt == BNC_LAST) begin
                        state   <= PRESS;
                        cnt     <= '0;
                        pressed <= 1'b1;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        lfsr    <= lfsr_nx;
                        pressed <= lfsr_nx[0];
                    end
                end
                BOUNCE_OUT: begin
                    if (cnt == BNC_LAST) begin
                        state   <= GAP;
                        cnt     <= '0;
                        pressed <= 1'b0;
                        done_q  <= GAP_ONE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        lfsr    <= lfsr_nx;
                        pressed <= lfsr_nx[0];
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator with scoreboard and scanner model
module tb_keypad_emulator;

    localparam int HOLD_W = 16;
    localparam int GAP    = 32;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BNC = 32;
`else
    localparam int BNC = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_key = 4'h0;
    logic [HOLD_W-1:0] req_hold = '0;
    logic [3:0]        tb_col = 4'h0;
    logic [3:0]        col;
    logic [3:0]        row;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_count = 0;
    int exp_q[$];

    logic       scan_en = 1'b0;
    logic [1:0] scan_c  = 2'd0;
    int         scan_t  = 0;
    int         hits    = 0;
    logic [3:0] key_val = 4'h0;

    assign col = scan_en ? ~(4'b0001 << scan_c) : tb_col;

    keypad_emulator #(
        .HOLD_W     (HOLD_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_key   (req_key),
        .req_hold  (req_hold),
        .col       (col),
        .row       (row),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (done) done_count++;

    // Key map as written in the keypad table: {column, row}.
    function automatic logic [3:0] tb_cr(input logic [3:0] k);
        case (k)
            4'hD: return {2'd0, 2'd0};
            4'hC: return {2'd0, 2'd1};
            4'hB: return {2'd0, 2'd2};
            4'hA: return {2'd0, 2'd3};
            4'hE: return {2'd1, 2'd0};
            4'h9: return {2'd1, 2'd1};
            4'h6: return {2'd1, 2'd2};
            4'h3: return {2'd1, 2'd3};
            4'h0: return {2'd2, 2'd0};
            4'h8: return {2'd2, 2'd1};
            4'h5: return {2'd2, 2'd2};
            4'h2: return {2'd2, 2'd3};
            4'hF: return {2'd3, 2'd0};
            4'h7: return {2'd3, 2'd1};
            4'h4: return {2'd3, 2'd2};
            default: return {2'd3, 2'd3};
        endcase
    endfunction

    // Scanner model: walks one low column every 8 cycles and decodes any low row.
    always @(negedge clk) begin
        if (!scan_en) begin
            scan_t = 0;
            scan_c = 2'd0;
        end else begin
            if (row != 4'hF) begin
                logic [1:0] r2;
                r2 = 2'd0;
                for (int i = 0; i < 4; i++) if (!row[i]) r2 = 2'(i);
                for (int kk = 0; kk < 16; kk++) begin
                    if (tb_cr(4'(kk)) == {scan_c, r2}) key_val = 4'(kk);
                end
                hits++;
            end
            scan_t++;
            if (scan_t == 8) begin
                scan_t = 0;
                scan_c = scan_c + 2'd1;
            end
        end
    end

    task automatic send(input logic [3:0] k, input int h);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready) begin
            $display("FAIL send_ready: req_ready=%0b required 1 within bound", req_ready);
        end else begin
            n_pass++;
            req_valid = 1'b1;
            req_key   = k;
            req_hold  = HOLD_W'(h);
            exp_q.push_back(cyc + ((h == 0) ? 1 : h) + GAP + BNC);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int e;
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL %s_timeout: done=%0b required 1 within bound", name, done);
        end else if (exp_q.size() == 0) begin
            $display("FAIL %s_unexpected: done at cycle %0d with nothing pending", name, cyc);
        end else begin
            e = exp_q.pop_front();
            if (cyc !== e) $display("FAIL %s_latency: done at cycle %0d required %0d", name, cyc, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tb_col = 4'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (row !== 4'hF) $display("FAIL reset_row: row=%h required f", row); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%0b required 1", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%0b required 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: done=%0b required 0", done); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_key5();
        send(4'h5, 100);
        repeat (3 + BNC / 2) @(negedge clk);
        tb_col = 4'b1011; #1;
        n_checks++; if (row !== 4'b1011) $display("FAIL key5_col2: row=%b required 1011", row); else n_pass++;
        tb_col = 4'b1110; #1;
        n_checks++; if (row !== 4'hF) $display("FAIL key5_col0: row=%b required 1111", row); else n_pass++;
        tb_col = 4'h0; #1;
        n_checks++; if (row !== 4'b1011) $display("FAIL key5_idle: row=%b required 1011", row); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL key5_busy: busy=%0b required 1", busy); else n_pass++;
        wait_done("key5");
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL key5_ready_after: req_ready=%0b required 1", req_ready); else n_pass++;
    endtask

    task automatic test_keys();
        logic [3:0] keys [3] = '{4'hD, 4'h1, 4'hF};
        logic [3:0] cols [3] = '{4'b1110, 4'b0111, 4'b0111};
        logic [3:0] rows [3] = '{4'b1110, 4'b0111, 4'b1110};
        for (int i = 0; i < 3; i++) begin
            send(keys[i], 20);
            repeat (2 + BNC / 2) @(negedge clk);
            tb_col = cols[i]; #1;
            n_checks++;
            if (row !== rows[i]) $display("FAIL keys_%h: row=%b required %b", keys[i], row, rows[i]);
            else n_pass++;
            tb_col = 4'h0;
            wait_done("keys");
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int done_cyc;
        tb_col = 4'h0;
        n = 0;
        done_cyc = -100;
        @(negedge clk);
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        req_valid = 1'b1;
        req_key   = 4'h3;
        req_hold  = '0;
        exp_q.push_back(cyc + 1 + GAP + BNC);
        @(posedge clk); #1;
        req_key  = 4'h4;
        req_hold = HOLD_W'(2);
`ifndef KEYPAD_EMU_BOUNCE_EN
        @(negedge clk);
        n_checks++; if (row !== 4'b0111) $display("FAIL hold0_press: row=%b required 0111", row); else n_pass++;
        @(negedge clk);
        n_checks++; if (row !== 4'hF) $display("FAIL hold0_len: row=%b required 1111", row); else n_pass++;
`endif
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            if (done) begin
                int e;
                done_cyc = cyc;
                e = exp_q.pop_front();
                n_checks++;
                if (cyc !== e) $display("FAIL b2b_first_done: cycle %0d required %0d", cyc, e); else n_pass++;
            end
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (cyc !== done_cyc + 1) $display("FAIL b2b_accept: accepted at cycle %0d required %0d", cyc, done_cyc + 1);
        else n_pass++;
        exp_q.push_back(cyc + 2 + GAP + BNC);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done("b2b_second");
    endtask

    task automatic test_reset_mid();
        int snap;
        tb_col = 4'h0;
        send(4'h6, 200);
        repeat (10 + BNC / 2) @(negedge clk);
        n_checks++; if (row !== 4'b1011) $display("FAIL rst_mid_pressed: row=%b required 1011", row); else n_pass++;
        snap = done_count;
        reset = 1'b1; #1;
        n_checks++; if (row !== 4'hF) $display("FAIL rst_mid_row: row=%b required 1111", row); else n_pass++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: req_ready=%0b required 1", req_ready); else n_pass++;
        repeat (300) @(negedge clk);
        n_checks++; if (done_count !== snap) $display("FAIL rst_mid_nodone: done pulses=%0d required %0d", done_count, snap); else n_pass++;
    endtask

    task automatic test_stable();
        int bad;
        bad = 0;
        tb_col = 4'h0;
        send(4'h9, 20 + BNC / 2);
        for (int i = 0; i < 20 + BNC / 2; i++) begin
            @(negedge clk);
            if (i >= BNC / 2 && row !== 4'b1101) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL stable_row: unstable cycles=%0d required 0", bad); else n_pass++;
        wait_done("stable");
    endtask

    task automatic test_scanner();
        int h0;
        scan_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            h0 = hits;
            send(4'(k), 2000);
            wait_done("scan");
            n_checks++;
            if (hits <= h0 || key_val !== 4'(k))
                $display("FAIL scan_key_%0d: key_val=%h key_en=%0b required %h key_en=1", k, key_val, hits > h0, 4'(k));
            else n_pass++;
        end
        scan_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key5();
        test_keys();
        test_back_to_back();
        test_reset_mid();
        test_stable();
        test_scanner();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
